uart_upg_loader: RTL and testbench

UART_UPG_LOADER -- requirements
Module: uart_upg_loader

---
 rtl/upg_pkg.sv | 23 ++
 rtl/uart_rx_core.sv | 95 +++++++++
 rtl/uart_upg_loader.sv | 107 ++++++++++
 tb/tb_uart_upg_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// Shared constants for the UART firmware-upgrade loader: FSM state codes, address width, word-count limit.
// Latency: n/a (package).
// Backpressure: n/a (package).
package upg_pkg;

    localparam int UPG_ADR_W     = 14;
    localparam int UPG_MAX_WORDS = 16384;
    localparam int UPG_CNT_W     = 15;

    localparam logic [2:0] ST_CNT_LO = 3'd0;
    localparam logic [2:0] ST_CNT_HI = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UPG_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM   = 3'd3;
`endif
    localparam logic [2:0] ST_DONE   = 3'd4;

    // A word count larger than the address space is truncated to a full-memory load.
    function automatic logic [UPG_CNT_W-1:0] clip_count(input logic [15:0] n);
        return (n > 16'(UPG_MAX_WORDS)) ? UPG_CNT_W'(UPG_MAX_WORDS) : n[UPG_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, glitch-rejecting start detect, centre sampling.
// Latency: byte_valid/frame_err pulse ~2 cycles after the stop-bit centre.
// Backpressure: none; the consumer must take rx_byte in the byte_valid cycle.
module uart_rx_core #(
    parameter int DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_prev;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_s = sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync       <= 2'b11;
            rx_prev    <= 1'b1;
            st         <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx_i};
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        st  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at the start-bit centre means it was only a glitch.
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) st <= RX_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        st  <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_upg_loader.sv
// UART upgrade loader: count + little-endian words -> memory write strobes; UPG_CHECKSUM_EN adds a trailing XOR byte.
// Latency: write strobe 1 cycle after the 4th byte of a word is received; done 1 cycle after the last strobe.
// Backpressure: none; the memory must accept every one-cycle strobe.
module uart_upg_loader
    import upg_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic                 Upg_wen_o,
    output logic [UPG_ADR_W-1:0] Upg_adr_o,
    output logic [31:0]          Upg_dat_o,
    output logic                 Upg_done_o,
    output logic                 Upg_err_o
);

    localparam int DIV = CLK_FREQ / BAUD;

`ifdef UPG_CHECKSUM_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_CSUM;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

    logic [7:0]           rx_byte;
    logic                 byte_valid;
    logic                 frame_err;
    logic [2:0]           state;
    logic [7:0]           cnt_lo;
    logic [UPG_CNT_W-1:0] words_left;
    logic [1:0]           byte_idx;
    logic [23:0]          dat_buf;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]           xor_acc;
`endif

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx_i       (rx_i),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_CNT_LO;
            cnt_lo     <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            dat_buf    <= '0;
            Upg_wen_o  <= 1'b0;
            Upg_adr_o  <= '0;
            Upg_dat_o  <= '0;
            Upg_done_o <= 1'b0;
            Upg_err_o  <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            xor_acc    <= '0;
`endif
        end else begin
            Upg_wen_o <= 1'b0;
            if (Upg_wen_o)         Upg_adr_o  <= Upg_adr_o + UPG_ADR_W'(1);
            if (frame_err)         Upg_err_o  <= 1'b1;
            // Entering DONE coincides with the last strobe, so done lands one cycle later.
            if (state == ST_DONE)  Upg_done_o <= 1'b1;
            if (byte_valid) begin
                case (state)
                    ST_CNT_LO: begin
                        cnt_lo <= rx_byte;
                        state  <= ST_CNT_HI;
                    end
                    ST_CNT_HI: begin
                        words_left <= clip_count({rx_byte, cnt_lo});
                        byte_idx   <= '0;
                        state      <= ({rx_byte, cnt_lo} == 16'd0) ? ST_AFTER_DATA : ST_DATA;
                    end
                    ST_DATA: begin
`ifdef UPG_CHECKSUM_EN
                        xor_acc  <= xor_acc ^ rx_byte;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            Upg_wen_o  <= 1'b1;
                            Upg_dat_o  <= {rx_byte, dat_buf};
                            words_left <= words_left - UPG_CNT_W'(1);
                            if (words_left == UPG_CNT_W'(1)) state <= ST_AFTER_DATA;
                        end else begin
                            dat_buf <= {rx_byte, dat_buf[23:8]};
                        end
                    end
`ifdef UPG_CHECKSUM_EN
                    ST_CSUM: begin
                        if (rx_byte != xor_acc) Upg_err_o <= 1'b1;
                        state <= ST_DONE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_upg_loader.sv
// Bench for uart_upg_loader: serial byte stimulus, frame-level reference model, immediate-assertion checks.
`timescale 1ns/1ps
module tb_uart_upg_loader;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_i  = 1'b1;
    logic        Upg_wen_o;
    logic [13:0] Upg_adr_o;
    logic [31:0] Upg_dat_o;
    logic        Upg_done_o;
    logic        Upg_err_o;

    uart_upg_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_i       (rx_i),
        .Upg_wen_o  (Upg_wen_o),
        .Upg_adr_o  (Upg_adr_o),
        .Upg_dat_o  (Upg_dat_o),
        .Upg_done_o (Upg_done_o),
        .Upg_err_o  (Upg_err_o)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: strobes observed since the last reset
    logic [45:0] got_q[$];
    int          last_wen_cyc;
    int          done_cyc;
    bit          overlap;
    bit          done_prev;

    always @(negedge clock) begin
        if (reset) begin
            got_q.delete();
            last_wen_cyc = -1;
            done_cyc     = -1;
            overlap      = 1'b0;
            done_prev    = 1'b0;
        end else begin
            if (Upg_wen_o) begin
                got_q.push_back({Upg_adr_o, Upg_dat_o});
                last_wen_cyc = cyc;
            end
            if (Upg_wen_o && Upg_done_o) overlap = 1'b1;
            if (Upg_done_o && !done_prev) done_cyc = cyc;
            done_prev = Upg_done_o;
        end
    end

    // Good bytes of the current frame, as the loader should have accepted them
    logic [7:0] frm[$];
    bit         bad_sent;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (DIV) tick();
        end
        rx_i = stop;
        repeat (DIV) tick();
        rx_i = 1'b1;
        repeat (2 * DIV) tick();
    endtask

    task automatic tx_good(input logic [7:0] b);
        tx_byte(b, 1'b1);
        frm.push_back(b);
    endtask

    task automatic tx_bad(input logic [7:0] b);
        tx_byte(b, 1'b0);
        bad_sent = 1'b1;
    endtask

    task automatic tx_csum();
`ifdef UPG_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < frm.size(); i++) x ^= frm[i];
        tx_good(x);
`endif
    endtask

    task automatic do_reset();
        rx_i  = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        frm.delete();
        bad_sent = 1'b0;
        tick();
    endtask

    // Reference model: parse the accepted byte stream as count + words (+ checksum)
    task automatic check_frame(input string tag);
        int          n;
        int          nbytes;
        int          words;
        bit          exp_done;
        bit          exp_err;
        logic [45:0] e;
        logic [7:0]  x;
        repeat (4 * DIV) tick();
        n = {frm[1], frm[0]};
        if (n > 16384) n = 16384;
        nbytes = frm.size() - 2;
        words  = nbytes / 4;
        if (words > n) words = n;
`ifdef UPG_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 4 * n && i < nbytes; i++) x ^= frm[2 + i];
        exp_done = (nbytes > 4 * n);
        exp_err  = bad_sent || (exp_done && frm[2 + 4 * n] != x);
`else
        x        = 8'h00;
        exp_done = (nbytes >= 4 * n);
        exp_err  = bad_sent || (x != 8'h00);
`endif
        check({tag, " strobe count"}, got_q.size(), words);
        for (int w = 0; w < words && w < got_q.size(); w++) begin
            e = {w[13:0], frm[2 + 4 * w + 3], frm[2 + 4 * w + 2], frm[2 + 4 * w + 1], frm[2 + 4 * w]};
            check({tag, " strobe adr/dat"}, got_q[w], e);
        end
        check({tag, " done"}, Upg_done_o, exp_done);
        check({tag, " err"}, Upg_err_o, exp_err);
        check({tag, " wen&done overlap"}, overlap, 1'b0);
`ifndef UPG_CHECKSUM_EN
        if (words > 0 && exp_done) check({tag, " done lag"}, done_cyc - last_wen_cyc, 1);
`endif
    endtask

    initial begin
        int n;

        // Reset state, sampled while reset is held
        repeat (2) tick();
        check("reset wen",  Upg_wen_o,  1'b0);
        check("reset adr",  Upg_adr_o,  14'd0);
        check("reset dat",  Upg_dat_o,  32'd0);
        check("reset done", Upg_done_o, 1'b0);
        check("reset err",  Upg_err_o,  1'b0);

        // Two-word frame
        do_reset();
        tx_good(8'h02); tx_good(8'h00);
        tx_good(8'h78); tx_good(8'h56); tx_good(8'h34); tx_good(8'h12);
        tx_good(8'hEF); tx_good(8'hBE); tx_good(8'hAD); tx_good(8'hDE);
        tx_csum();
        check_frame("two_words");
        check("two_words w0", got_q.size() > 0 ? got_q[0] : 46'd0, {14'd0, 32'h12345678});
        check("two_words w1", got_q.size() > 1 ? got_q[1] : 46'd0, {14'd1, 32'hDEADBEEF});
        check("two_words adr after", Upg_adr_o, 14'd2);

        // Empty frame; trailing byte ignored in DONE
        do_reset();
        tx_good(8'h00); tx_good(8'h00);
        tx_csum();
        check_frame("n_zero");
        tx_good(8'h55);
        check_frame("n_zero trailing");

        // Framing error inside a word
        do_reset();
        tx_good(8'h01); tx_good(8'h00);
        tx_good(8'hAA); tx_good(8'hBB);
        tx_bad(8'h77);
        check("frame_err err early", Upg_err_o, 1'b1);
        check("frame_err no strobe yet", got_q.size(), 0);
        tx_good(8'hCC); tx_good(8'hDD);
        tx_csum();
        check_frame("frame_err");

        // Reset in the middle of a word
        do_reset();
        tx_good(8'h03); tx_good(8'h00); tx_good(8'h11); tx_good(8'h22);
        do_reset();
        tx_good(8'h01); tx_good(8'h00);
        tx_good(8'h04); tx_good(8'h03); tx_good(8'h02); tx_good(8'h01);
        tx_csum();
        check_frame("mid_reset");
        check("mid_reset w0", got_q.size() > 0 ? got_q[0] : 46'd0, {14'd0, 32'h01020304});

        // Short low glitch on an idle line
        do_reset();
        rx_i = 1'b0;
        repeat (5) tick();
        rx_i = 1'b1;
        repeat (4 * DIV) tick();
        check("glitch strobes", got_q.size(), 0);
        check("glitch err", Upg_err_o, 1'b0);
        check("glitch done", Upg_done_o, 1'b0);
        tx_good(8'h01); tx_good(8'h00);
        tx_good(8'h5A); tx_good(8'hA5); tx_good(8'h3C); tx_good(8'hC3);
        tx_csum();
        check_frame("after_glitch");

        // Count above the address space is clipped; only a prefix is sent
        do_reset();
        tx_good(8'hFF); tx_good(8'hFF);
        for (int i = 0; i < 8; i++) tx_good(8'($urandom));
        check_frame("clip_partial");

        // Randomized frames
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 4);
            tx_good(8'(n)); tx_good(8'h00);
            for (int i = 0; i < 4 * n; i++) tx_good(8'($urandom));
            tx_csum();
            check_frame("random");
        end

`ifdef UPG_CHECKSUM_EN
        do_reset();
        tx_good(8'h01); tx_good(8'h00);
        tx_good(8'h11); tx_good(8'h22); tx_good(8'h33); tx_good(8'h44);
        tx_good(8'h44);
        check_frame("csum_ok");
        check("csum_ok err", Upg_err_o, 1'b0);
        do_reset();
        tx_good(8'h01); tx_good(8'h00);
        tx_good(8'h11); tx_good(8'h22); tx_good(8'h33); tx_good(8'h44);
        tx_good(8'h00);
        check_frame("csum_bad");
        check("csum_bad err", Upg_err_o, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
